// File: rtl/gbe_tx_arb.sv
// gbe_tx_arb: two-source (application / CPU) frame arbiter feeding a byte-wide
// GbE MAC transmit interface. A winner is registered in IDLE and owns the MAC
// for one whole frame. Frames longer than MAX_BYTES are cut on the MAC side
// and the remaining source bytes are drained silently. IFG_CYCLES idle cycles
// are forced between frames.
//
// Parameters:
//   IFG_CYCLES   idle cycles between frames (0 = back-to-back)
//   MAX_BYTES    maximum bytes sent on the MAC per frame before truncation
//   CPU_PRIORITY 0 = round-robin on a tie, 1 = CPU always wins a tie
//
// Ports:
//   mac_tx_clk, mac_tx_rst_n      clock, synchronous active-low reset
//   app_req/cpu_req               source holds a complete frame (level)
//   app_data/cpu_data             source head byte (first-word-fall-through)
//   app_eof/cpu_eof               head byte is the last byte of the frame
//   app_rd/cpu_rd                 pop the source head byte this cycle
//   app_gnt/cpu_gnt               source owns the MAC for the current frame
//   mac_tx_data, mac_tx_dvld      byte to the MAC and its valid
//   mac_tx_ack                    MAC accepted the byte this cycle
//   arb_busy                      arbiter not idle
//   arb_trunc                     one-cycle pulse when a frame is truncated
//   app_frames/cpu_frames         per-source frame counters, only present when
//                                 GBE_TX_ARB_STATS_EN is defined
module gbe_tx_arb #(
  parameter int IFG_CYCLES   = 12,
  parameter int MAX_BYTES    = 2048,
  parameter int CPU_PRIORITY = 0
) (
  input  logic       mac_tx_clk,
  input  logic       mac_tx_rst_n,
  input  logic       app_req,
  input  logic [7:0] app_data,
  input  logic       app_eof,
  output logic       app_rd,
  output logic       app_gnt,
  input  logic       cpu_req,
  input  logic [7:0] cpu_data,
  input  logic       cpu_eof,
  output logic       cpu_rd,
  output logic       cpu_gnt,
  output logic [7:0] mac_tx_data,
  output logic       mac_tx_dvld,
  input  logic       mac_tx_ack,
  output logic       arb_busy,
  output logic       arb_trunc
`ifdef GBE_TX_ARB_STATS_EN
  ,
  output logic [15:0] app_frames,
  output logic [15:0] cpu_frames
`endif
);

  localparam int CW = (MAX_BYTES > 2) ? $clog2(MAX_BYTES) : 1;
  localparam int GW = (IFG_CYCLES > 2) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BYTES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;
  // With no inter-frame gap the end of a frame returns straight to IDLE.
  localparam logic [1:0] S_POST  = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;

  logic [1:0]    state_q, state_d;
  logic          sel_cpu_q, sel_cpu_d;    // granted source, 1 = CPU
  logic          last_cpu_q, last_cpu_d;  // last served source, 1 = CPU
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          trunc_q, trunc_d;

  logic send, drain, own, pop, head_eof;

  assign send     = (state_q == S_SEND);
  assign drain    = (state_q == S_DRAIN);
  assign own      = send | drain;
  assign head_eof = sel_cpu_q ? cpu_eof : app_eof;
  // Gated by reset so an aborted frame never loses a byte from its source.
  assign pop      = mac_tx_rst_n & ((send & mac_tx_ack) | drain);

  assign app_rd      = pop & ~sel_cpu_q;
  assign cpu_rd      = pop & sel_cpu_q;
  assign app_gnt     = own & ~sel_cpu_q;
  assign cpu_gnt     = own & sel_cpu_q;
  assign mac_tx_data = send ? (sel_cpu_q ? cpu_data : app_data) : '0;
  assign mac_tx_dvld = send;
  assign arb_busy    = (state_q != S_IDLE);
  assign arb_trunc   = trunc_q;

  always_comb begin
    state_d    = state_q;
    sel_cpu_d  = sel_cpu_q;
    last_cpu_d = last_cpu_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    trunc_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (app_req || cpu_req) begin
          state_d = S_SEND;
          cnt_d   = '0;
          if (app_req && cpu_req)
            sel_cpu_d = (CPU_PRIORITY != 0) ? 1'b1 : ~last_cpu_q;
          else
            sel_cpu_d = cpu_req;
        end
      end
      S_SEND: begin
        if (mac_tx_ack) begin
          cnt_d = cnt_q + CW'(1);
          if (head_eof) begin
            state_d    = S_POST;
            gap_d      = '0;
            last_cpu_d = sel_cpu_q;
          end else if (cnt_q == CNT_LAST) begin
            state_d    = S_DRAIN;
            trunc_d    = 1'b1;
            last_cpu_d = sel_cpu_q;
          end
        end
      end
      S_DRAIN: begin
        if (head_eof) begin
          state_d = S_POST;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mac_tx_clk) begin
    if (!mac_tx_rst_n) begin
      state_q    <= S_IDLE;
      sel_cpu_q  <= 1'b0;
      last_cpu_q <= 1'b1;
      cnt_q      <= '0;
      gap_q      <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_cpu_q  <= sel_cpu_d;
      last_cpu_q <= last_cpu_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      trunc_q    <= trunc_d;
    end
  end

`ifdef GBE_TX_ARB_STATS_EN
  // A frame is counted when it completes or when it is cut at MAX_BYTES.
  logic frame_end;
  assign frame_end = send & mac_tx_ack & (head_eof | (cnt_q == CNT_LAST));

  always_ff @(posedge mac_tx_clk) begin
    if (!mac_tx_rst_n) begin
      app_frames <= '0;
      cpu_frames <= '0;
    end else if (frame_end) begin
      if (sel_cpu_q) cpu_frames <= cpu_frames + 16'd1;
      else           app_frames <= app_frames + 16'd1;
    end
  end
`endif

endmodule
